// File: rtl/vector_pkg.sv
// Shared types and constants for the vector ASIP writeback stage.
package vector_pkg;

  localparam int LANES = 4;
  localparam logic [7:0] PIX_MAX = 8'd255;
  localparam logic [1:0] LAST_LANE = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    STORE = 1'b1
  } wb_state_t;

  typedef logic [1:0] lane_idx_t;

endpackage

// File: rtl/pixel_sat.sv
// Clamp a signed lane value into the 0..255 pixel range.
module pixel_sat
  import vector_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] din,
  output logic [7:0]    dout
);

  // Negative -> 0, anything with bits above 7 set -> PIX_MAX, else pass low byte.
  always_comb begin
    dout = 8'd0;
    if (din[DW-1]) begin
      dout = 8'd0;
    end else if (|din[DW-2:8]) begin
      dout = PIX_MAX;
    end else begin
      dout = din[7:0];
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage: register-bank writeback plus a 4-lane serializer into
// the write-only output memory, holding execute via stall while it drains.
module writeback_unit
  import vector_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          wr_pxl,
  input  logic          wr_mul_reg,
  input  logic          wr_pos,
  input  logic          wr_mul_pos,
  input  logic          wr_wom,
  input  logic [AW-1:0] wom_addr,
  input  logic [DW-1:0] res1,
  input  logic [DW-1:0] res2,
  input  logic [DW-1:0] res3,
  input  logic [DW-1:0] res4,
  output logic          stall,
  output logic          we_pxl,
  output logic          wr_pos_pxl,
  output logic [DW-1:0] wdp1,
  output logic [DW-1:0] wdp2,
  output logic [DW-1:0] wdp3,
  output logic [DW-1:0] wdp4,
  output logic          we_mul,
  output logic          wr_mul_pos_in,
  output logic [DW-1:0] wdm1,
  output logic [DW-1:0] wdm2,
  output logic [DW-1:0] wdm3,
  output logic [DW-1:0] wdm4,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata
);

  logic [DW-1:0] res_s [LANES];
  logic [DW-1:0] lane_r [LANES];
  logic [DW-1:0] wdp_r [LANES];
  logic [DW-1:0] wdm_r [LANES];

  wb_state_t     state_r, state_nxt_s;
  lane_idx_t     k_r, k_nxt_s;
  logic [AW-1:0] base_r, base_nxt_s;

  logic          stall_s, accept_s, accept_wom_s, store_nxt_s;
  logic [DW-1:0] sel_lane_s;
  logic [7:0]    sat_s;

  logic          we_pxl_r, wr_pos_pxl_r, we_mul_r, wr_mul_pos_r;
  logic          mem_we_r;
  logic [AW-1:0] mem_addr_r;
  logic [7:0]    mem_wdata_r;

  assign res_s[0] = res1;
  assign res_s[1] = res2;
  assign res_s[2] = res3;
  assign res_s[3] = res4;

  // The last store cycle does not stall, so a following WOM store can chain in.
  assign stall_s      = (state_r == STORE) && (k_r != LAST_LANE);
  assign accept_s     = in_valid && !stall_s;
  assign accept_wom_s = accept_s && wr_wom;
  assign store_nxt_s  = (state_nxt_s == STORE);

  // Serializer next-state: lane counter and base address for the next cycle.
  always_comb begin
    state_nxt_s = state_r;
    k_nxt_s     = k_r;
    base_nxt_s  = base_r;
    case (state_r)
      IDLE: begin
        if (accept_wom_s) begin
          state_nxt_s = STORE;
          k_nxt_s     = 2'd0;
          base_nxt_s  = wom_addr;
        end else begin
          state_nxt_s = IDLE;
          k_nxt_s     = 2'd0;
        end
      end
      STORE: begin
        if (k_r != LAST_LANE) begin
          state_nxt_s = STORE;
          k_nxt_s     = k_r + 2'd1;
        end else if (accept_wom_s) begin
          state_nxt_s = STORE;
          k_nxt_s     = 2'd0;
          base_nxt_s  = wom_addr;
        end else begin
          state_nxt_s = IDLE;
          k_nxt_s     = 2'd0;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        k_nxt_s     = 2'd0;
      end
    endcase
  end

  // Lane feeding the next WOM byte: fresh input lane 0 on a new store, else the captured lane.
  always_comb begin
    sel_lane_s = '0;
    if (accept_wom_s) begin
      sel_lane_s = res_s[0];
    end else begin
      sel_lane_s = lane_r[k_nxt_s];
    end
  end

  pixel_sat #(.DW(DW)) u_pixel_sat (
    .din  (sel_lane_s),
    .dout (sat_s)
  );

  // Serializer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      k_r     <= 2'd0;
      base_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      k_r     <= k_nxt_s;
      base_r  <= base_nxt_s;
    end
  end

  // Lane capture on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        lane_r[i] <= '0;
      end
    end else if (accept_s) begin
      for (int i = 0; i < LANES; i++) begin
        lane_r[i] <= res_s[i];
      end
    end
  end

  // WOM write port, registered from the next-cycle serializer view.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 8'd0;
    end else begin
      mem_we_r <= store_nxt_s;
      if (store_nxt_s) begin
        mem_addr_r  <= base_nxt_s + {{(AW-2){1'b0}}, k_nxt_s};
        mem_wdata_r <= sat_s;
      end
    end
  end

  // Pixel bank write port; data and half select hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_pxl_r     <= 1'b0;
      wr_pos_pxl_r <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        wdp_r[i] <= '0;
      end
    end else begin
      we_pxl_r <= accept_s && wr_pxl;
      if (accept_s && wr_pxl) begin
        wr_pos_pxl_r <= wr_pos;
        for (int i = 0; i < LANES; i++) begin
          wdp_r[i] <= res_s[i];
        end
      end
    end
  end

  // Multiply bank write port; data and half select hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_mul_r     <= 1'b0;
      wr_mul_pos_r <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        wdm_r[i] <= '0;
      end
    end else begin
      we_mul_r <= accept_s && wr_mul_reg;
      if (accept_s && wr_mul_reg) begin
        wr_mul_pos_r <= wr_mul_pos;
        for (int i = 0; i < LANES; i++) begin
          wdm_r[i] <= res_s[i];
        end
      end
    end
  end

  assign stall         = stall_s;
  assign we_pxl        = we_pxl_r;
  assign wr_pos_pxl    = wr_pos_pxl_r;
  assign wdp1          = wdp_r[0];
  assign wdp2          = wdp_r[1];
  assign wdp3          = wdp_r[2];
  assign wdp4          = wdp_r[3];
  assign we_mul        = we_mul_r;
  assign wr_mul_pos_in = wr_mul_pos_r;
  assign wdm1          = wdm_r[0];
  assign wdm2          = wdm_r[1];
  assign wdm3          = wdm_r[2];
  assign wdm4          = wdm_r[3];
  assign mem_we        = mem_we_r;
  assign mem_addr      = mem_addr_r;
  assign mem_wdata     = mem_wdata_r;

endmodule

// File: tb/tb_writeback_unit.sv
// Table-driven, scoreboarded bench for writeback_unit.
module tb_writeback_unit;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, wr_pxl, wr_mul_reg, wr_pos, wr_mul_pos, wr_wom;
  logic [AW-1:0] wom_addr;
  logic [DW-1:0] res1, res2, res3, res4;
  logic          stall, we_pxl, wr_pos_pxl, we_mul, wr_mul_pos_in, mem_we;
  logic [DW-1:0] wdp1, wdp2, wdp3, wdp4, wdm1, wdm2, wdm3, wdm4;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;

  always #5 clk = ~clk;

  writeback_unit #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .wr_pxl(wr_pxl),
    .wr_mul_reg(wr_mul_reg), .wr_pos(wr_pos), .wr_mul_pos(wr_mul_pos),
    .wr_wom(wr_wom), .wom_addr(wom_addr),
    .res1(res1), .res2(res2), .res3(res3), .res4(res4),
    .stall(stall), .we_pxl(we_pxl), .wr_pos_pxl(wr_pos_pxl),
    .wdp1(wdp1), .wdp2(wdp2), .wdp3(wdp3), .wdp4(wdp4),
    .we_mul(we_mul), .wr_mul_pos_in(wr_mul_pos_in),
    .wdm1(wdm1), .wdm2(wdm2), .wdm3(wdm3), .wdm4(wdm4),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  typedef struct {
    logic             pxl, mul, pos, mpos, wom;
    logic [31:0]      addr;
    logic [3:0][31:0] res;
    logic [3:0][7:0]  exp;
  } vec_t;

  typedef struct packed {
    logic [31:0]      cyc;
    logic             pos;
    logic [3:0][31:0] data;
  } reg_exp_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] addr;
    logic [7:0]  data;
  } mem_exp_t;

  vec_t        tbl [10];
  vec_t        idle_v, cur;
  logic        cur_valid;
  reg_exp_t    pxlq[$], mulq[$];
  mem_exp_t    memq[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] cyc = 32'd0;
  logic        model_store;
  logic [1:0]  model_k;
  logic [3:0][31:0] last_wdp, last_wdm;
  logic        last_pos, last_mpos;

  function automatic vec_t mk(input logic pxl, input logic mul, input logic pos,
                              input logic mpos, input logic wom, input logic [31:0] addr,
                              input logic [31:0] r0, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [31:0] r3,
                              input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
    vec_t v;
    v.pxl = pxl; v.mul = mul; v.pos = pos; v.mpos = mpos; v.wom = wom;
    v.addr = addr;
    v.res[0] = r0; v.res[1] = r1; v.res[2] = r2; v.res[3] = r3;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input vec_t v, input logic valid);
    cur = v; cur_valid = valid;
    in_valid = valid; wr_pxl = v.pxl; wr_mul_reg = v.mul; wr_pos = v.pos;
    wr_mul_pos = v.mpos; wr_wom = v.wom; wom_addr = v.addr;
    res1 = v.res[0]; res2 = v.res[1]; res3 = v.res[2]; res4 = v.res[3];
  endtask

  task automatic check_outputs();
    reg_exp_t r;
    mem_exp_t m;
    chk("stall", stall, model_store && (model_k != 2'd3));
    if (we_pxl) begin
      if (pxlq.size() == 0) chk("pxl_unexpected", 1'b1, 1'b0);
      else begin
        r = pxlq.pop_front();
        chk("pxl_cycle", cyc, r.cyc);
        chk("wr_pos_pxl", wr_pos_pxl, r.pos);
        chk("wdp", {wdp4, wdp3, wdp2, wdp1}, r.data);
        last_wdp = r.data; last_pos = r.pos;
      end
    end else begin
      if (pxlq.size() != 0 && pxlq[0].cyc <= cyc) begin
        chk("pxl_missing", 1'b0, 1'b1);
        r = pxlq.pop_front();
      end
      chk("wdp_hold", {wr_pos_pxl, wdp4, wdp3, wdp2, wdp1}, {last_pos, last_wdp});
    end
    if (we_mul) begin
      if (mulq.size() == 0) chk("mul_unexpected", 1'b1, 1'b0);
      else begin
        r = mulq.pop_front();
        chk("mul_cycle", cyc, r.cyc);
        chk("wr_mul_pos_in", wr_mul_pos_in, r.pos);
        chk("wdm", {wdm4, wdm3, wdm2, wdm1}, r.data);
        last_wdm = r.data; last_mpos = r.pos;
      end
    end else begin
      if (mulq.size() != 0 && mulq[0].cyc <= cyc) begin
        chk("mul_missing", 1'b0, 1'b1);
        r = mulq.pop_front();
      end
      chk("wdm_hold", {wr_mul_pos_in, wdm4, wdm3, wdm2, wdm1}, {last_mpos, last_wdm});
    end
    if (mem_we) begin
      if (memq.size() == 0) chk("mem_unexpected", 1'b1, 1'b0);
      else begin
        m = memq.pop_front();
        chk("mem_cycle", cyc, m.cyc);
        chk("mem_addr", mem_addr, m.addr);
        chk("mem_wdata", mem_wdata, m.data);
      end
    end else if (memq.size() != 0 && memq[0].cyc <= cyc) begin
      chk("mem_missing", 1'b0, 1'b1);
      m = memq.pop_front();
    end
  endtask

  // One clock edge: the model decides acceptance and queues expectations, then outputs are checked.
  task automatic tick(output logic acc);
    logic     mstall;
    reg_exp_t r;
    mem_exp_t m;
    mstall = model_store && (model_k != 2'd3);
    acc = cur_valid && !mstall;
    if (acc) begin
      if (cur.pxl) begin
        r.cyc = cyc + 32'd1; r.pos = cur.pos; r.data = cur.res; pxlq.push_back(r);
      end
      if (cur.mul) begin
        r.cyc = cyc + 32'd1; r.pos = cur.mpos; r.data = cur.res; mulq.push_back(r);
      end
      if (cur.wom) begin
        for (int i = 0; i < 4; i++) begin
          m.cyc = cyc + 32'd1 + 32'(i);
          m.addr = cur.addr + 32'(i);
          m.data = cur.exp[i];
          memq.push_back(m);
        end
      end
    end
    if (mstall) model_k = model_k + 2'd1;
    else if (acc && cur.wom) begin model_store = 1'b1; model_k = 2'd0; end
    else begin model_store = 1'b0; model_k = 2'd0; end
    @(posedge clk);
    cyc = cyc + 32'd1;
    #1;
    check_outputs();
  endtask

  task automatic issue(input vec_t v);
    logic acc;
    int   n;
    drive(v, 1'b1);
    acc = 1'b0;
    n = 0;
    while (!acc && n < 8) begin
      tick(acc);
      n++;
    end
    if (!acc) chk("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    logic acc;
    drive(idle_v, 1'b0);
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  initial begin
    idle_v = mk(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 8'd0, 8'd0, 8'd0, 8'd0);
    tbl[0] = mk(0, 0, 0, 0, 1, 32'h100, 32'd10, 32'd300, -32'sd5, 32'd255, 8'd10, 8'd255, 8'd0, 8'd255);
    tbl[1] = mk(1, 0, 1, 0, 0, 32'h0, 32'd150, 32'd160, 32'd170, 32'd180, 8'd0, 8'd0, 8'd0, 8'd0);
    tbl[2] = mk(0, 1, 0, 0, 0, 32'h0, 32'd15, 32'd16, 32'd17, 32'd18, 8'd0, 8'd0, 8'd0, 8'd0);
    tbl[3] = mk(1, 0, 0, 0, 1, 32'h40, 32'd0, 32'd256, -32'sd1, 32'd128, 8'd0, 8'd255, 8'd0, 8'd128);
    tbl[4] = mk(0, 0, 0, 0, 1, 32'h10, 32'd1, 32'd2, 32'd3, 32'd4, 8'd1, 8'd2, 8'd3, 8'd4);
    tbl[5] = mk(0, 0, 0, 0, 1, 32'h20, -32'sd100, 32'd1000, 32'd7, 32'd200, 8'd0, 8'd255, 8'd7, 8'd200);
    tbl[6] = mk(0, 0, 0, 0, 1, 32'hFFFFFFFE, 32'd255, 32'h80000000, 32'h7FFFFFFF, 32'd254,
                8'd255, 8'd0, 8'd255, 8'd254);
    tbl[7] = mk(1, 1, 1, 1, 0, 32'h0, 32'd5, 32'd6, 32'd7, 32'd8, 8'd0, 8'd0, 8'd0, 8'd0);
    tbl[8] = mk(0, 0, 1, 1, 0, 32'h55, 32'd99, 32'd98, 32'd97, 32'd96, 8'd0, 8'd0, 8'd0, 8'd0);
    tbl[9] = mk(1, 0, 0, 0, 0, 32'h0, -32'sd1, -32'sd2, 32'h80000000, 32'd256, 8'd0, 8'd0, 8'd0, 8'd0);

    model_store = 1'b0; model_k = 2'd0;
    last_wdp = '0; last_wdm = '0; last_pos = 1'b0; last_mpos = 1'b0;
    drive(idle_v, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_we_pxl", we_pxl, 1'b0);
    chk("rst_we_mul", we_mul, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 8'h0);
    chk("rst_wdp", {wr_pos_pxl, wdp4, wdp3, wdp2, wdp1}, 129'h0);
    chk("rst_wdm", {wr_mul_pos_in, wdm4, wdm3, wdm2, wdm1}, 129'h0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-store: three lanes go out, reset during the third drops mem_we at once.
    issue(tbl[0]);
    idle(2);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_mem_we", mem_we, 1'b0);
    chk("rst_mid_stall", stall, 1'b0);
    memq.delete();
    model_store = 1'b0; model_k = 2'd0;
    last_wdp = '0; last_wdm = '0; last_pos = 1'b0; last_mpos = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(4);

    // Pixel writeback, then multiply writeback on the next cycle.
    issue(tbl[1]);
    issue(tbl[2]);
    idle(3);

    // Register write coincides with lane-0 WOM store.
    issue(tbl[3]);
    idle(5);

    // Back-to-back WOM stores with in_valid held high.
    issue(tbl[4]);
    issue(tbl[5]);
    idle(6);

    // Address wrap-around and extreme saturation values.
    issue(tbl[6]);
    idle(5);

    // Non-WOM instruction held during stall is taken once, on the k=3 cycle.
    issue(tbl[4]);
    issue(tbl[1]);
    idle(4);

    // Non-WOM table sweep at one instruction per cycle.
    foreach (tbl[i]) begin
      if (!tbl[i].wom) issue(tbl[i]);
    end
    idle(3);

    chk("pxlq_drained", 32'(pxlq.size()), 32'd0);
    chk("mulq_drained", 32'(mulq.size()), 32'd0);
    chk("memq_drained", 32'(memq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
